// File: rtl/vram_slot_arbiter_if.sv
// CPU-side VRAM bus: level request held until a one-cycle ack,
// with a combinational wait back to the Z80.
interface vram_slot_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_ack;
    logic              cpu_wait;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack, cpu_wait
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack, cpu_wait
    );
endinterface

// File: rtl/vram_slot_arbiter.sv
// Single-port VRAM slot arbiter: video fetch owns fixed pixel phases
// during active display, the Z80 bus gets every other slot.
module vram_slot_arbiter #(
    parameter int         ADDR_W     = 10,
    parameter int         DATA_W     = 8,
    parameter logic [3:0] VID_PHASES = 4'b0101
) (
    input  logic              clk_pix,
    input  logic              reset_n,
    input  logic [7:0]        h,
    input  logic              hbl,
    input  logic              vbl,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_dout,
    output logic              vid_valid,
    vram_slot_arbiter_if.slave cpu,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_q
);
    typedef enum logic [1:0] {
        IDLE,
        PEND,
        ISSUED,
        WAITQ
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_VID
    } owner_t;

    state_t            state;
    owner_t            own1;
    owner_t            own2;
    logic              req_seen;
    logic              done;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_din;
    logic              vslot;
    logic              unused_h;

    assign vslot    = !hbl && !vbl && VID_PHASES[h[1:0]];
    assign unused_h = ^h[7:2];

    assign cpu.cpu_wait = cpu.cpu_req && !done;

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            req_seen     <= 1'b0;
            done         <= 1'b0;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_din      <= '0;
            cpu.cpu_dout <= '0;
            cpu.cpu_ack  <= 1'b0;
        end else begin
            cpu.cpu_ack <= 1'b0;
            // request must drop before another access may start
            if (!cpu.cpu_req) begin
                req_seen <= 1'b0;
                done     <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (cpu.cpu_req && !req_seen) begin
                        lat_we   <= cpu.cpu_we;
                        lat_addr <= cpu.cpu_addr;
                        lat_din  <= cpu.cpu_din;
                        req_seen <= 1'b1;
                        state    <= PEND;
                    end
                end
                PEND: begin
                    if (!vslot) begin
                        state <= ISSUED;
                    end
                end
                ISSUED: begin
                    state <= WAITQ;
                end
                WAITQ: begin
                    if (!lat_we) begin
                        cpu.cpu_dout <= ram_q;
                    end
                    cpu.cpu_ack <= 1'b1;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // video slot always wins the RAM port over a pending CPU access
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr <= '0;
            ram_we   <= 1'b0;
            ram_din  <= '0;
            own1     <= OWN_NONE;
        end else if (vslot) begin
            ram_addr <= vid_addr;
            ram_we   <= 1'b0;
            own1     <= OWN_VID;
        end else if (state == PEND) begin
            ram_addr <= lat_addr;
            ram_we   <= lat_we;
            ram_din  <= lat_din;
            own1     <= OWN_CPU;
        end else begin
            ram_we   <= 1'b0;
            own1     <= OWN_NONE;
        end
    end

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            own2      <= OWN_NONE;
            vid_valid <= 1'b0;
            vid_dout  <= '0;
        end else begin
            own2      <= own1;
            vid_valid <= (own2 == OWN_VID);
            if (own2 == OWN_VID) begin
                vid_dout <= ram_q;
            end
        end
    end
endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Scoreboard bench for vram_slot_arbiter: default-mask instance with a
// queued monitor, plus an all-phases instance checked inline.
module tb_vram_slot_arbiter;
    localparam int         AW     = 10;
    localparam int         DW     = 8;
    localparam logic [3:0] MASK_A = 4'b0101;

    logic          clk_pix = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    h;
    logic          hbl;
    logic          vbl;
    logic [AW-1:0] vid_addr;

    logic [DW-1:0] vid_dout_a, vid_dout_b;
    logic          vid_valid_a, vid_valid_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic          ram_we_a, ram_we_b;
    logic [DW-1:0] ram_din_a, ram_din_b;
    logic [DW-1:0] ram_q_a, ram_q_b;

    always #5 clk_pix = ~clk_pix;

    vram_slot_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_a ();
    vram_slot_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_b ();

    vram_slot_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .VID_PHASES(MASK_A)
    ) dut_a (
        .clk_pix(clk_pix), .reset_n(reset_n),
        .h(h), .hbl(hbl), .vbl(vbl), .vid_addr(vid_addr),
        .vid_dout(vid_dout_a), .vid_valid(vid_valid_a),
        .cpu(cpu_a.slave),
        .ram_addr(ram_addr_a), .ram_we(ram_we_a),
        .ram_din(ram_din_a), .ram_q(ram_q_a)
    );

    vram_slot_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .VID_PHASES(4'b1111)
    ) dut_b (
        .clk_pix(clk_pix), .reset_n(reset_n),
        .h(h), .hbl(hbl), .vbl(vbl), .vid_addr(vid_addr),
        .vid_dout(vid_dout_b), .vid_valid(vid_valid_b),
        .cpu(cpu_b.slave),
        .ram_addr(ram_addr_b), .ram_we(ram_we_b),
        .ram_din(ram_din_b), .ram_q(ram_q_b)
    );

    function automatic logic [7:0] iv(input int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    int         cyc = 0;
    logic [7:0] mem_a [1024];
    logic [7:0] mem_b [1024];

    always @(posedge clk_pix) cyc <= cyc + 1;

    always @(posedge clk_pix) begin
        if (cyc == 0) begin
            for (int i = 0; i < 1024; i++) mem_a[i] <= iv(i);
        end else if (ram_we_a) begin
            mem_a[ram_addr_a] <= ram_din_a;
        end
        ram_q_a <= mem_a[ram_addr_a];
    end

    always @(posedge clk_pix) begin
        if (cyc == 0) begin
            for (int i = 0; i < 1024; i++) mem_b[i] <= iv(i);
        end else if (ram_we_b) begin
            mem_b[ram_addr_b] <= ram_din_b;
        end
        ram_q_b <= mem_b[ram_addr_b];
    end

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t       vq[$];
    exp_t       cq[$];
    exp_t       ve, ce;
    logic [7:0] model [1024];
    logic [7:0] last_dout;
    int         checks = 0;
    int         errors = 0;
    int         vcnt = 0;
    int         acnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    // a video slot at the next edge must strobe three edge-counts later
    task automatic drive(input logic [7:0] hh, input logic hb,
                         input logic vb, input logic [AW-1:0] va);
        h = hh; hbl = hb; vbl = vb; vid_addr = va;
        if (!hb && !vb && MASK_A[hh[1:0]])
            vq.push_back('{model[va], cyc + 3});
        step();
    endtask

    task automatic cpu_start(input logic we, input logic [AW-1:0] a,
                             input logic [7:0] d, input int lat);
        cpu_a.cpu_req = 1'b1; cpu_a.cpu_we = we;
        cpu_a.cpu_addr = a;   cpu_a.cpu_din = d;
        if (we) model[a] = d;
        else last_dout = model[a];
        cq.push_back('{last_dout, cyc + lat});
    endtask

    always @(negedge clk_pix) begin
        if (reset_n && vid_valid_a) begin
            vcnt++;
            if (vq.size() == 0) begin
                checks++; errors++;
                $display("FAIL vid_extra: strobe at cyc %0d, none queued", cyc);
            end else begin
                ve = vq.pop_front();
                chk("vid_dout", vid_dout_a, ve.d);
                chk("vid_cycle", cyc, ve.c);
            end
        end
        if (reset_n && cpu_a.cpu_ack) begin
            acnt++;
            if (cq.size() == 0) begin
                checks++; errors++;
                $display("FAIL cpu_extra: ack at cyc %0d, none queued", cyc);
            end else begin
                ce = cq.pop_front();
                chk("cpu_dout", cpu_a.cpu_dout, ce.d);
                chk("ack_cycle", cyc, ce.c);
                chk("wait_at_ack", cpu_a.cpu_wait, 0);
            end
        end
    end

    initial begin
        int a0, we_seen;
        for (int i = 0; i < 1024; i++) model[i] = iv(i);
        last_dout = 8'h00;
        h = 8'd0; hbl = 1'b1; vbl = 1'b1; vid_addr = '0;
        cpu_a.cpu_req = 1'b0; cpu_a.cpu_we = 1'b0;
        cpu_a.cpu_addr = '0;  cpu_a.cpu_din = '0;
        cpu_b.cpu_req = 1'b0; cpu_b.cpu_we = 1'b0;
        cpu_b.cpu_addr = '0;  cpu_b.cpu_din = '0;
        reset_n = 1'b0;
        step(); step();

        chk("rst_ram_addr", ram_addr_a, 0);
        chk("rst_ram_we", ram_we_a, 0);
        chk("rst_ram_din", ram_din_a, 0);
        chk("rst_vid_dout", vid_dout_a, 0);
        chk("rst_vid_valid", vid_valid_a, 0);
        chk("rst_cpu_dout", cpu_a.cpu_dout, 0);
        chk("rst_cpu_ack", cpu_a.cpu_ack, 0);
        chk("rst_cpu_wait", cpu_a.cpu_wait, 0);
        reset_n = 1'b1;
        step();

        // active line sweep, default mask, no CPU
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(8'(i), 1'b0, 1'b0, AW'(10'h100 + i));
            if (i == 0) chk("sweep_addr_h0", ram_addr_a, 10'h100);
            if (i == 1) chk("sweep_addr_h1", ram_addr_a, 10'h100);
            if (i == 2) chk("sweep_addr_h2", ram_addr_a, 10'h102);
            chk("sweep_we", ram_we_a, 0);
        end
        repeat (3) drive(8'd8, 1'b1, 1'b0, '0);
        chk("sweep_strobes", vcnt, 4);

        // CPU read colliding with the phase-0 video slot
        cpu_start(1'b0, 10'h3A5, 8'h00, 4);
        drive(8'd8, 1'b0, 1'b0, 10'h108);
        chk("rd_wait_pend", cpu_a.cpu_wait, 1);
        drive(8'd9, 1'b0, 1'b0, 10'h109);
        chk("rd_issue_addr", ram_addr_a, 10'h3A5);
        chk("rd_issue_we", ram_we_a, 0);
        drive(8'd10, 1'b0, 1'b0, 10'h10A);
        chk("rd_wait_busy", cpu_a.cpu_wait, 1);
        drive(8'd11, 1'b0, 1'b0, 10'h10B);
        drive(8'd12, 1'b0, 1'b0, 10'h10C);
        drive(8'd13, 1'b0, 1'b0, 10'h10D);
        cpu_a.cpu_req = 1'b0;
        repeat (3) drive(8'd14, 1'b1, 1'b0, '0);

        // CPU write in vblank, then a held request
        a0 = acnt;
        cpu_start(1'b1, 10'h010, 8'h5C, 4);
        drive(8'd0, 1'b0, 1'b1, '0);
        drive(8'd1, 1'b0, 1'b1, '0);
        chk("wr_we", ram_we_a, 1);
        chk("wr_addr", ram_addr_a, 10'h010);
        chk("wr_din", ram_din_a, 8'h5C);
        drive(8'd2, 1'b0, 1'b1, '0);
        chk("wr_we_once", ram_we_a, 0);
        drive(8'd3, 1'b0, 1'b1, '0);
        we_seen = 0;
        for (int i = 0; i < 20; i++) begin
            drive(8'(4 + i), 1'b0, 1'b1, '0);
            if (ram_we_a) we_seen++;
        end
        chk("held_no_we", we_seen, 0);
        chk("held_one_ack", acnt - a0, 1);
        chk("held_wait", cpu_a.cpu_wait, 0);
        cpu_a.cpu_req = 1'b0;
        drive(8'd30, 1'b0, 1'b1, '0);
        cpu_start(1'b0, 10'h010, 8'h00, 4);
        repeat (5) drive(8'd31, 1'b0, 1'b1, '0);
        cpu_a.cpu_req = 1'b0;
        drive(8'd32, 1'b0, 1'b1, '0);

        // all-phases mask: CPU held off until hblank
        cpu_b.cpu_req = 1'b1; cpu_b.cpu_we = 1'b0;
        cpu_b.cpu_addr = 10'h044;
        for (int i = 0; i < 6; i++) begin
            drive(8'(16 + i), 1'b0, 1'b0, AW'(10'h100 + i));
            chk("b_addr", ram_addr_b, 10'h100 + i);
            chk("b_we", ram_we_b, 0);
            chk("b_wait", cpu_b.cpu_wait, 1);
            if (i >= 2) begin
                chk("b_valid", vid_valid_b, 1);
                chk("b_dout", vid_dout_b, iv(10'h100 + i - 2));
            end
        end
        drive(8'd22, 1'b1, 1'b0, '0);
        chk("b_issue_addr", ram_addr_b, 10'h044);
        drive(8'd23, 1'b1, 1'b0, '0);
        chk("b_no_ack_yet", cpu_b.cpu_ack, 0);
        drive(8'd24, 1'b1, 1'b0, '0);
        chk("b_ack", cpu_b.cpu_ack, 1);
        chk("b_cpu_dout", cpu_b.cpu_dout, iv(10'h044));
        cpu_b.cpu_req = 1'b0;
        repeat (3) drive(8'd25, 1'b1, 1'b0, '0);

        // reset mid-PEND with request held
        cpu_a.cpu_req = 1'b1; cpu_a.cpu_we = 1'b1;
        cpu_a.cpu_addr = 10'h030; cpu_a.cpu_din = 8'hEE;
        drive(8'd0, 1'b0, 1'b1, '0);
        #2 reset_n = 1'b0;
        #1;
        chk("rstp_we", ram_we_a, 0);
        chk("rstp_wait", cpu_a.cpu_wait, 1);
        step();
        chk("rstp_ack", cpu_a.cpu_ack, 0);
        step();
        last_dout = 8'h00;
        reset_n = 1'b1;
        cpu_start(1'b1, 10'h030, 8'hEE, 4);
        drive(8'd1, 1'b0, 1'b1, '0);
        chk("post_rst_wait1", cpu_a.cpu_wait, 1);
        drive(8'd2, 1'b0, 1'b1, '0);
        drive(8'd3, 1'b0, 1'b1, '0);
        chk("post_rst_wait3", cpu_a.cpu_wait, 1);
        repeat (2) drive(8'd4, 1'b0, 1'b1, '0);
        cpu_a.cpu_req = 1'b0;
        drive(8'd5, 1'b0, 1'b1, '0);

        // reset while a write sits on ram_we
        cpu_a.cpu_req = 1'b1; cpu_a.cpu_we = 1'b1;
        cpu_a.cpu_addr = 10'h031; cpu_a.cpu_din = 8'h77;
        drive(8'd6, 1'b0, 1'b1, '0);
        drive(8'd7, 1'b0, 1'b1, '0);
        chk("rstw_we_set", ram_we_a, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstw_we_clr", ram_we_a, 0);
        cpu_a.cpu_req = 1'b0;
        step();
        reset_n = 1'b1;
        last_dout = 8'h00;
        drive(8'd8, 1'b0, 1'b1, '0);
        cpu_start(1'b0, 10'h031, 8'h00, 4);
        repeat (5) drive(8'd9, 1'b0, 1'b1, '0);
        cpu_a.cpu_req = 1'b0;
        repeat (3) drive(8'd10, 1'b0, 1'b1, '0);

        chk("vq_drained", vq.size(), 0);
        chk("cq_drained", cq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
